// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates EXU results and LSU load responses onto the register file write port.
// Latency: 1 cycle from handshake to registered write; one write per cycle sustained.
// Backpressure: LSU is always accepted outside reset; EXU is held off while an LSU response is valid.
//
// Ports:
//   clock_i, reset_i                  - core clock, synchronous active-high reset
//   exu_valid_i/exu_ready_o, exu_rd_i, exu_wdata_i
//                                     - execute-unit result handshake and payload
//   lsu_valid_i/lsu_ready_o, lsu_rd_i, lsu_funct3_i, lsu_byte_off_i, lsu_rdata_i
//                                     - load response handshake, load type, address offset, raw word
//   wbu_w_enable_o, rdt_addr_o, wbu_wdata_o
//                                     - registered register-file write port
//   du_stall_o                        - combinational: EXU result presented but not taken
//   instret_o                         - retired-instruction counter (wraps)
//   load_err_o                        - one-cycle pulse for an illegal or misaligned load
module writeback_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clock_i,
    input  logic             reset_i,

    input  logic             exu_valid_i,
    output logic             exu_ready_o,
    input  logic [4:0]       exu_rd_i,
    input  logic [XLEN-1:0]  exu_wdata_i,

    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic [4:0]       lsu_rd_i,
    input  logic [2:0]       lsu_funct3_i,
    input  logic [1:0]       lsu_byte_off_i,
    input  logic [XLEN-1:0]  lsu_rdata_i,

    output logic             wbu_w_enable_o,
    output logic [4:0]       rdt_addr_o,
    output logic [XLEN-1:0]  wbu_wdata_o,
    output logic             du_stall_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             load_err_o
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Arbitration: the LSU cannot be stalled (the load data is already
    // back from memory), so it always wins and the EXU waits.
    // ------------------------------------------------------------------
    logic lsu_take;
    logic exu_take;

    assign lsu_ready_o = ~reset_i;
    assign exu_ready_o = ~reset_i & ~lsu_valid_i;
    assign lsu_take    = lsu_valid_i & lsu_ready_o;
    assign exu_take    = exu_valid_i & exu_ready_o;
    assign du_stall_o  = exu_valid_i & ~exu_ready_o;

    // ------------------------------------------------------------------
    // Load formatting and legality
    // ------------------------------------------------------------------
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic            ld_legal;

    always_comb begin
        ld_byte  = lsu_rdata_i[{lsu_byte_off_i, 3'b000} +: 8];
        ld_half  = lsu_rdata_i[{lsu_byte_off_i[1], 4'b0000} +: 16];
        ld_data  = lsu_rdata_i;
        ld_legal = 1'b0;
        case (lsu_funct3_i)
            F3_LB: begin
                ld_data  = {{(XLEN-8){ld_byte[7]}}, ld_byte};
                ld_legal = 1'b1;
            end
            F3_LBU: begin
                ld_data  = {{(XLEN-8){1'b0}}, ld_byte};
                ld_legal = 1'b1;
            end
            F3_LH: begin
                ld_data  = {{(XLEN-16){ld_half[15]}}, ld_half};
                ld_legal = ~lsu_byte_off_i[0];
            end
            F3_LHU: begin
                ld_data  = {{(XLEN-16){1'b0}}, ld_half};
                ld_legal = ~lsu_byte_off_i[0];
            end
            F3_LW: begin
                ld_data  = lsu_rdata_i;
                ld_legal = (lsu_byte_off_i == 2'b00);
            end
            default: begin
                ld_data  = lsu_rdata_i;
                ld_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Select the winning result this cycle
    // ------------------------------------------------------------------
    logic            acc;       // a result is retired this cycle
    logic            acc_err;   // accepted load was illegal
    logic [4:0]      acc_rd;
    logic [XLEN-1:0] acc_data;

    always_comb begin
        acc      = 1'b0;
        acc_err  = 1'b0;
        acc_rd   = 5'd0;
        acc_data = '0;
        if (lsu_take) begin
            acc      = ld_legal;
            acc_err  = ~ld_legal;
            acc_rd   = lsu_rd_i;
            acc_data = ld_data;
        end else if (exu_take) begin
            acc      = 1'b1;
            acc_rd   = exu_rd_i;
            acc_data = exu_wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Output register. Address/data only move on a real write so they
    // hold their last value while the enable is low; writes to x0 retire
    // but never reach the register file.
    // ------------------------------------------------------------------
    logic             wen_q;
    logic [4:0]       addr_q;
    logic [XLEN-1:0]  data_q;
    logic [CNT_W-1:0] instret_q;
    logic             err_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wen_q     <= 1'b0;
            addr_q    <= 5'd0;
            data_q    <= '0;
            instret_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wen_q <= acc & (acc_rd != 5'd0);
            err_q <= acc_err;
            if (acc) begin
                instret_q <= instret_q + CNT_ONE;
            end
            if (acc && (acc_rd != 5'd0)) begin
                addr_q <= acc_rd;
                data_q <= acc_data;
            end
        end
    end

    assign wbu_w_enable_o = wen_q;
    assign rdt_addr_o     = addr_q;
    assign wbu_wdata_o    = data_q;
    assign instret_o      = instret_q;
    assign load_err_o     = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios followed by randomized traffic,
// all compared against a behavioural reference model.
module tb_writeback_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             exu_valid;
    logic             exu_ready;
    logic [4:0]       exu_rd;
    logic [XLEN-1:0]  exu_wdata;
    logic             lsu_valid;
    logic             lsu_ready;
    logic [4:0]       lsu_rd;
    logic [2:0]       lsu_funct3;
    logic [1:0]       lsu_off;
    logic [XLEN-1:0]  lsu_rdata;
    logic             wen;
    logic [4:0]       waddr;
    logic [XLEN-1:0]  wdata;
    logic             stall;
    logic [CNT_W-1:0] instret;
    logic             lerr;

    always #5 clk = ~clk;

    writeback_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .exu_valid_i    (exu_valid),
        .exu_ready_o    (exu_ready),
        .exu_rd_i       (exu_rd),
        .exu_wdata_i    (exu_wdata),
        .lsu_valid_i    (lsu_valid),
        .lsu_ready_o    (lsu_ready),
        .lsu_rd_i       (lsu_rd),
        .lsu_funct3_i   (lsu_funct3),
        .lsu_byte_off_i (lsu_off),
        .lsu_rdata_i    (lsu_rdata),
        .wbu_w_enable_o (wen),
        .rdt_addr_o     (waddr),
        .wbu_wdata_o    (wdata),
        .du_stall_o     (stall),
        .instret_o      (instret),
        .load_err_o     (lerr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state: what the register-file port should show.
    bit          m_wen;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    bit [63:0]   m_instret;
    bit          m_err;

    function automatic bit load_ok(input bit [2:0] f3, input bit [1:0] off);
        int size_bytes;
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b0;
        size_bytes = 1 << f3[1:0];
        return (int'(off) % size_bytes) == 0;
    endfunction

    function automatic bit [31:0] fmt_load(input bit [2:0] f3, input bit [1:0] off, input bit [31:0] raw);
        bit [31:0] v;
        v = raw;
        if (f3 == 0 || f3 == 4) begin
            v = (raw >> (8 * int'(off))) & 32'hFF;
            if (f3 == 0 && v >= 32'h80) v = v - 32'h100;
        end else if (f3 == 1 || f3 == 5) begin
            v = (raw >> (16 * (int'(off) / 2))) & 32'hFFFF;
            if (f3 == 1 && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    // One clock: check combinational handshake outputs, advance the model,
    // clock the DUT, then compare registered outputs. Reports whether the EXU
    // result was taken so the source knows whether to hold it.
    task automatic cycle(output bit exu_taken);
        bit lsu_taken;
        bit retire;
        bit [4:0]  rd;
        bit [31:0] d;
        #1;
        chk("lsu_ready", lsu_ready, !rst);
        chk("exu_ready", exu_ready, !rst && !lsu_valid);
        chk("du_stall",  stall, exu_valid && (rst || lsu_valid));
        lsu_taken = !rst && lsu_valid;
        exu_taken = !rst && !lsu_valid && exu_valid;
        retire = 1'b0;
        rd = 5'd0;
        d  = 32'd0;
        if (rst) begin
            m_wen = 0; m_addr = 0; m_data = 0; m_instret = 0; m_err = 0;
        end else begin
            m_wen = 0;
            m_err = 0;
            if (lsu_taken) begin
                if (load_ok(lsu_funct3, lsu_off)) begin
                    retire = 1'b1;
                    rd = lsu_rd;
                    d  = fmt_load(lsu_funct3, lsu_off, lsu_rdata);
                end else begin
                    m_err = 1'b1;
                end
            end else if (exu_taken) begin
                retire = 1'b1;
                rd = exu_rd;
                d  = exu_wdata;
            end
            if (retire) begin
                m_instret = m_instret + 64'd1;
                if (rd != 0) begin
                    m_wen = 1'b1; m_addr = rd; m_data = d;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("w_enable", wen, m_wen);
        chk("rdt_addr", waddr, m_addr);
        chk("wdata",    wdata, m_data);
        chk("instret",  instret, m_instret);
        chk("load_err", lerr, m_err);
    endtask

    task automatic set_exu(input bit v, input bit [4:0] rd, input bit [31:0] d);
        exu_valid = v; exu_rd = rd; exu_wdata = d;
    endtask

    task automatic set_lsu(input bit v, input bit [4:0] rd, input bit [2:0] f3,
                           input bit [1:0] off, input bit [31:0] d);
        lsu_valid = v; lsu_rd = rd; lsu_funct3 = f3; lsu_off = off; lsu_rdata = d;
    endtask

    initial begin
        bit taken;
        bit [63:0] base;

        rst = 1'b1;
        set_exu(1, 5'd9, 32'hCAFE);
        set_lsu(0, 0, 0, 0, 0);
        cycle(taken);
        cycle(taken);
        chk("reset_w_enable", wen, 0);
        chk("reset_instret", instret, 0);
        rst = 1'b0;
        set_exu(0, 0, 0);
        cycle(taken);

        // EXU only
        set_exu(1, 5'd5, 32'h0000_1234);
        cycle(taken);
        chk("exu_only_en", wen, 1);
        chk("exu_only_addr", waddr, 5);
        chk("exu_only_data", wdata, 32'h0000_1234);
        chk("exu_only_instret", instret, 1);
        set_exu(0, 0, 0);
        cycle(taken);
        chk("exu_only_drop", wen, 0);

        // Simultaneous valids: LSU first, EXU held one cycle
        set_lsu(1, 5'd3, 3'b010, 2'd0, 32'hDEAD_BEEF);
        set_exu(1, 5'd4, 32'h11);
        #1;
        chk("simul_stall", stall, 1);
        cycle(taken);
        chk("simul_lw", wdata, 32'hDEAD_BEEF);
        chk("simul_exu_held", taken, 0);
        set_lsu(0, 0, 0, 0, 0);
        cycle(taken);
        chk("simul_exu", wdata, 32'h11);
        chk("simul_instret", instret, 3);
        set_exu(0, 0, 0);

        // Load formatting
        set_lsu(1, 5'd10, 3'b000, 2'd0, 32'h8070_F0A5); cycle(taken);
        chk("lb_off0", wdata, 32'hFFFF_FFA5);
        set_lsu(1, 5'd11, 3'b100, 2'd1, 32'h8070_F0A5); cycle(taken);
        chk("lbu_off1", wdata, 32'h0000_00F0);
        set_lsu(1, 5'd12, 3'b001, 2'd2, 32'h8070_F0A5); cycle(taken);
        chk("lh_off2", wdata, 32'hFFFF_8070);
        set_lsu(1, 5'd13, 3'b101, 2'd2, 32'h8070_F0A5); cycle(taken);
        chk("lhu_off2", wdata, 32'h0000_8070);

        // Errors
        base = instret;
        set_lsu(1, 5'd14, 3'b001, 2'd1, 32'h8070_F0A5); cycle(taken);
        chk("lh_mis_err", lerr, 1);
        chk("lh_mis_nowrite", wen, 0);
        chk("lh_mis_instret", instret, base);
        set_lsu(1, 5'd14, 3'b011, 2'd0, 32'h8070_F0A5); cycle(taken);
        chk("f3_011_err", lerr, 1);
        chk("f3_011_nowrite", wen, 0);
        set_lsu(0, 0, 0, 0, 0); cycle(taken);
        chk("err_pulse_end", lerr, 0);

        // x0 write retires without writing
        base = instret;
        set_exu(1, 5'd0, 32'hFFFF_FFFF); cycle(taken);
        chk("x0_nowrite", wen, 0);
        chk("x0_instret", instret, base + 1);

        // Handshake then reset: write still visible, then cleared
        set_exu(1, 5'd7, 32'h77); cycle(taken);
        chk("pre_reset_write", wen, 1);
        set_exu(0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_cycle_visible", wdata, 32'h77);
        cycle(taken);
        chk("post_reset_en", wen, 0);
        chk("post_reset_data", wdata, 0);
        chk("post_reset_instret", instret, 0);
        rst = 1'b0;

        // Back-to-back EXU
        for (int i = 1; i <= 8; i++) begin
            set_exu(1, 5'(i), 32'h100 + 32'(i));
            cycle(taken);
            chk("b2b_en", wen, 1);
            chk("b2b_addr", waddr, 64'(i));
        end
        chk("b2b_instret", instret, 8);
        set_exu(0, 0, 0);
        cycle(taken);

        // Randomized traffic; an EXU result is held until taken
        taken = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (taken || !exu_valid) begin
                set_exu($urandom_range(0, 2) != 0,
                        ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                        $urandom);
            end
            set_lsu($urandom_range(0, 2) == 0,
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                    3'($urandom), 2'($urandom), $urandom);
            cycle(taken);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
